led_game_seq: RTL and testbench

- Parameterised successor to the Lab_7 LED reaction-game controller.
- Generalised to NUM_LEDS channels and multi-round play, with a play window that shrinks each round, false-start detection and a game-complete state.
- Sits directly under the board-level top.
- Consumes the slow game tick as its clock and the debounced win-round button (winrnd); drives the LED driver enable and channel select.

---
 rtl/led_game_pkg.sv | 33 +++
 rtl/led_game_lfsr.sv | 22 ++
 rtl/led_game_seq.sv | 200 ++++++++++++++++++++
 tb/tb_led_game_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/led_game_pkg.sv
// Shared types and helpers for the LED reaction game.
// Build option LED_GAME_LFSR_EN selects a pseudo-random target channel.
package led_game_pkg;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_SHOW  = 3'd1,
    S_DARK  = 3'd2,
    S_PLAY  = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 taps on bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [15:0] play_window(
    input logic [15:0] rnd,
    input logic [15:0] base,
    input logic [15:0] dec,
    input logic [15:0] lim
  );
    logic [31:0] prod;
    logic [15:0] red;
    prod = 32'(rnd) * 32'(dec);
    if (prod >= 32'(base)) return lim;
    red = base - prod[15:0];
    return (red < lim) ? lim : red;
  endfunction

endpackage

// File: rtl/led_game_lfsr.sv
// 8-bit Fibonacci LFSR, advances every cycle.
// Used only when LED_GAME_LFSR_EN is defined.
module led_game_lfsr
  import led_game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] o_lfsr
);

  logic [7:0] r_lfsr;
  logic       w_fb;

  assign w_fb   = ^(r_lfsr & LFSR_TAPS);
  assign o_lfsr = r_lfsr;

  always_ff @(posedge clk) begin
    if (!rst) r_lfsr <= LFSR_SEED;
    else      r_lfsr <= {r_lfsr[6:0], w_fb};
  end

endmodule

// File: rtl/led_game_seq.sv
// Multi-round LED reaction game sequencer with shrinking play window.
// Define LED_GAME_LFSR_EN for an LFSR-chosen target channel.
module led_game_seq
  import led_game_pkg::*;
#(
  parameter int NUM_LEDS   = 4,
  parameter int CTRL_W     = 2,
  parameter int CLR_TICKS  = 4,
  parameter int STEP_TICKS = 128,
  parameter int DARK_TICKS = 256,
  parameter int PLAY_TICKS = 512,
  parameter int PLAY_DEC   = 64,
  parameter int PLAY_MIN   = 64,
  parameter int MAX_ROUND  = 8,
  parameter int RND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winrnd,
  output logic              clr,
  output logic              leds_on,
  output logic [CTRL_W-1:0] leds_ctrl,
  output logic [RND_W-1:0]  round,
  output logic              game_done
);

  localparam logic [15:0] CLR_END  = 16'(CLR_TICKS - 1);
  localparam logic [15:0] STEP_END = 16'(STEP_TICKS - 1);
  localparam logic [15:0] DARK_END = 16'(DARK_TICKS - 1);
  localparam logic [CTRL_W-1:0] LAST = CTRL_W'(NUM_LEDS - 1);
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(MAX_ROUND - 1);
  localparam bit POW2 = ((NUM_LEDS & (NUM_LEDS - 1)) == 0);

  state_e            r_state;
  logic [15:0]       r_cnt;
  logic [CTRL_W-1:0] r_step;
  logic [RND_W-1:0]  r_round;
  logic              r_win_q;

  logic              w_press;
  logic              w_last_rnd;
  logic [15:0]       w_win_end;
  logic [CTRL_W-1:0] w_tgt;
  logic [CTRL_W-1:0] w_dark_tgt;

  assign w_press    = winrnd & ~r_win_q;
  assign w_last_rnd = (r_round == LAST_RND);
  assign w_win_end  = play_window(16'(r_round), 16'(PLAY_TICKS),
                                  16'(PLAY_DEC), 16'(PLAY_MIN)) - 16'd1;
  assign round      = r_round;

`ifdef LED_GAME_LFSR_EN
  logic [7:0]        w_lfsr;
  logic [CTRL_W-1:0] r_tgt;
  logic              w_dark_in;

  led_game_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .o_lfsr (w_lfsr)
  );

  assign w_dark_in  = (r_state == S_SHOW) && (r_cnt == STEP_END) &&
                      (r_step == LAST);
  assign w_dark_tgt = CTRL_W'(w_lfsr % 8'(NUM_LEDS));
  assign w_tgt      = r_tgt;

  always_ff @(posedge clk) begin
    if (!rst)           r_tgt <= '0;
    else if (w_dark_in) r_tgt <= w_dark_tgt;
  end
`else
  if (POW2) begin : g_trunc
    assign w_tgt = CTRL_W'(r_round);
  end else begin : g_mod
    // round mod NUM_LEDS tracked alongside round itself
    logic [CTRL_W-1:0] r_mod;
    logic              w_inc;
    logic              w_clr;

    assign w_inc = (r_state == S_WIN) && !w_last_rnd;
    assign w_clr = (r_state == S_LOSE);
    assign w_tgt = r_mod;

    always_ff @(posedge clk) begin
      if (!rst || w_clr) r_mod <= '0;
      else if (w_inc)    r_mod <= (r_mod == LAST) ? '0
                                  : r_mod + CTRL_W'(1);
    end
  end
  assign w_dark_tgt = w_tgt;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_CLEAR;
      r_cnt     <= '0;
      r_round   <= '0;
      r_step    <= '0;
      r_win_q   <= 1'b0;
      clr       <= 1'b1;
      leds_on   <= 1'b0;
      leds_ctrl <= '0;
      game_done <= 1'b0;
    end else begin
      r_win_q <= winrnd;
      r_cnt   <= r_cnt + 16'd1;
      unique case (r_state)
        S_CLEAR: begin
          if (r_cnt == CLR_END) begin
            r_state   <= S_SHOW;
            r_cnt     <= '0;
            r_step    <= '0;
            clr       <= 1'b0;
            leds_on   <= 1'b1;
            leds_ctrl <= '0;
          end
        end
        S_SHOW: begin
          if (r_cnt == STEP_END) begin
            r_cnt <= '0;
            if (r_step == LAST) begin
              r_state   <= S_DARK;
              r_step    <= '0;
              leds_on   <= 1'b0;
              leds_ctrl <= w_dark_tgt;
            end else begin
              r_step    <= r_step + CTRL_W'(1);
              leds_ctrl <= r_step + CTRL_W'(1);
            end
          end
        end
        S_DARK: begin
          if (w_press) begin
            r_state <= S_LOSE;
            r_cnt   <= '0;
            clr     <= 1'b1;
            leds_on <= 1'b0;
          end else if (r_cnt == DARK_END) begin
            r_state   <= S_PLAY;
            r_cnt     <= '0;
            leds_on   <= 1'b1;
            leds_ctrl <= w_tgt;
          end
        end
        S_PLAY: begin
          // a press on the final window cycle still wins
          if (w_press) begin
            r_state <= S_WIN;
            r_cnt   <= '0;
          end else if (r_cnt == w_win_end) begin
            r_state <= S_LOSE;
            r_cnt   <= '0;
            clr     <= 1'b1;
            leds_on <= 1'b0;
          end
        end
        S_WIN: begin
          r_cnt     <= '0;
          r_step    <= '0;
          leds_ctrl <= '0;
          if (w_last_rnd) begin
            r_state   <= S_DONE;
            game_done <= 1'b1;
          end else begin
            r_state <= S_SHOW;
            r_round <= r_round + RND_W'(1);
          end
        end
        S_LOSE: begin
          r_state   <= S_CLEAR;
          r_cnt     <= '0;
          r_round   <= '0;
          leds_ctrl <= '0;
        end
        S_DONE: begin
          if (r_cnt == STEP_END) begin
            r_cnt <= '0;
            if (r_step == LAST) begin
              r_step    <= '0;
              leds_ctrl <= '0;
            end else begin
              r_step    <= r_step + CTRL_W'(1);
              leds_ctrl <= r_step + CTRL_W'(1);
            end
          end
        end
        default: begin
          r_state   <= S_CLEAR;
          r_cnt     <= '0;
          clr       <= 1'b1;
          leds_on   <= 1'b0;
          leds_ctrl <= '0;
          game_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_game_seq.sv
// Directed bench for led_game_seq (default build).
// Cycle k means "just after the k-th rising edge since the last reset edge".
module tb_led_game_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       winrnd = 1'b0;
  logic       clr;
  logic       leds_on;
  logic [1:0] leds_ctrl;
  logic [2:0] round;
  logic       game_done;

  int n_run  = 0;
  int n_fail = 0;

  led_game_seq dut (
    .clk       (clk),
    .rst       (rst),
    .winrnd    (winrnd),
    .clr       (clr),
    .leds_on   (leds_on),
    .leds_ctrl (leds_ctrl),
    .round     (round),
    .game_done (game_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0;
    winrnd = 1'b0;
    adv(2);
    chk("rst_clr", int'(clr), 1);
    chk("rst_on", int'(leds_on), 0);
    chk("rst_ctrl", int'(leds_ctrl), 0);
    chk("rst_done", int'(game_done), 0);
    chk("rst_round", int'(round), 0);
    rst = 1'b1;

    // power-up sequence: CLEAR 4, SHOW 4x128, DARK 256
    adv(3);
    chk("clr_k3", int'(clr), 1);
    adv(1);
    chk("clr_k4", int'(clr), 0);
    chk("show_on", int'(leds_on), 1);
    chk("show_c0", int'(leds_ctrl), 0);
    adv(127);
    chk("show_k131", int'(leds_ctrl), 0);
    adv(1);
    chk("show_c1", int'(leds_ctrl), 1);
    adv(128);
    chk("show_c2", int'(leds_ctrl), 2);
    adv(128);
    chk("show_c3", int'(leds_ctrl), 3);
    adv(127);
    chk("show_k515", int'(leds_on), 1);
    adv(1);
    chk("dark_on", int'(leds_on), 0);
    chk("dark_ctrl", int'(leds_ctrl), 0);
    adv(255);
    chk("dark_k771", int'(leds_on), 0);
    adv(1);
    chk("play_on", int'(leds_on), 1);
    chk("play_ctrl", int'(leds_ctrl), 0);

    // win round 0 with a 2-cycle press 100 cycles into PLAY
    adv(100);
    winrnd = 1'b1;
    adv(1);
    chk("win_clr", int'(clr), 0);
    chk("win_on", int'(leds_on), 1);
    chk("win_round", int'(round), 0);
    adv(1);
    winrnd = 1'b0;
    chk("r1_round", int'(round), 1);
    chk("r1_show", int'(leds_ctrl), 0);
    adv(768);
    chk("r1_play_on", int'(leds_on), 1);
    chk("r1_play_ctrl", int'(leds_ctrl), 1);
    adv(447);
    chk("r1_w447_on", int'(leds_on), 1);
    chk("r1_w447_clr", int'(clr), 0);
    adv(1);
    chk("r1_lose_clr", int'(clr), 1);
    chk("r1_lose_on", int'(leds_on), 0);
    adv(1);
    chk("r1_clr_round", int'(round), 0);
    chk("r1_clr_clr", int'(clr), 1);

    // false start in DARK at cycle 600 of the new attempt
    adv(599);
    chk("fs_dark", int'(leds_on), 0);
    winrnd = 1'b1;
    adv(1);
    chk("fs_lose_clr", int'(clr), 1);
    chk("fs_lose_on", int'(leds_on), 0);
    winrnd = 1'b0;
    adv(1);
    chk("fs_clear_clr", int'(clr), 1);
    chk("fs_round", int'(round), 0);

    // no press: LOSE exactly 512 cycles after PLAY entry
    adv(772);
    chk("to_play_on", int'(leds_on), 1);
    adv(511);
    chk("to_w511_clr", int'(clr), 0);
    adv(1);
    chk("to_lose_clr", int'(clr), 1);
    chk("to_round", int'(round), 0);
    adv(1);
    chk("to_clear_rnd", int'(round), 0);

    // eight straight wins
    adv(772);
    for (int r = 0; r < 8; r++) begin
      chk("run_ctrl", int'(leds_ctrl), r % 4);
      chk("run_round", int'(round), r);
      if (r < 7) begin
        adv(9);
        winrnd = 1'b1;
        adv(1);
        adv(1);
        winrnd = 1'b0;
        adv(768);
      end
    end
    // round 7 window is 64: press seen on its last cycle
    adv(63);
    chk("r7_w63_on", int'(leds_on), 1);
    winrnd = 1'b1;
    adv(1);
    chk("r7_win_clr", int'(clr), 0);
    chk("r7_win_done", int'(game_done), 0);
    adv(1);
    winrnd = 1'b0;
    chk("done_flag", int'(game_done), 1);
    chk("done_on", int'(leds_on), 1);
    chk("done_c0", int'(leds_ctrl), 0);
    adv(128);
    chk("done_c1", int'(leds_ctrl), 1);
    adv(384);
    chk("done_wrap", int'(leds_ctrl), 0);
    chk("done_hold", int'(game_done), 1);
    adv(10);
    rst = 1'b0;
    adv(1);
    chk("drst_done", int'(game_done), 0);
    chk("drst_clr", int'(clr), 1);
    chk("drst_round", int'(round), 0);
    chk("drst_on", int'(leds_on), 0);
    rst = 1'b1;

    // level held from SHOW into DARK is not a press
    adv(100);
    winrnd = 1'b1;
    adv(500);
    chk("held_dark_on", int'(leds_on), 0);
    chk("held_dark_clr", int'(clr), 0);
    winrnd = 1'b0;
    adv(172);
    chk("held_play_on", int'(leds_on), 1);
    chk("held_play_clr", int'(clr), 0);

    // reset in the middle of PLAY
    adv(50);
    rst = 1'b0;
    adv(1);
    chk("prst_clr", int'(clr), 1);
    chk("prst_on", int'(leds_on), 0);
    chk("prst_round", int'(round), 0);
    rst = 1'b1;
    adv(4);
    chk("prst_show", int'(leds_on), 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
